// File: rtl/nibble_serial_accumulator_pkg.sv
// nibble_serial_accumulator_pkg: shared types and constants for the nibble-serial accumulator
package nibble_serial_accumulator_pkg;
  typedef enum logic [1:0] {IDLE, ADD, RESP} state_e;
  localparam int NIBBLE_W = 4;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/nibble_serial_accumulator_if.sv
// nibble_serial_accumulator_if: operand/result handshake bundle for the accumulator
interface nibble_serial_accumulator_if #(parameter int W = 16);
  logic in_valid, in_ready, in_sub, acc_clr;
  logic [W-1:0] in_data, out_data;
  logic out_valid, out_ready, out_carry, out_ovf, busy;
  modport master (
    output in_valid, in_data, in_sub, acc_clr, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_ovf, busy
  );
  modport slave (
    input  in_valid, in_data, in_sub, acc_clr, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_ovf, busy
  );
endinterface

// File: rtl/nibble_serial_accumulator_rca.sv
// ripple_carry_adder: 4-bit ripple-carry adder slice
module ripple_carry_adder
  import nibble_serial_accumulator_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);
  logic [NIBBLE_W:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_accumulator.sv
// nibble_serial_accumulator: add/sub accumulator reusing one 4-bit adder slice nibble-serially
module nibble_serial_accumulator
  import nibble_serial_accumulator_pkg::*;
#(parameter int W = 16)
(
  input logic clk,
  input logic rst_n,
  nibble_serial_accumulator_if.slave bus
);
  localparam int N  = W / NIBBLE_W;
  localparam int IW = idx_w(N);
  state_e state_q, state_d;
  logic [W-1:0] acc_q, acc_d, opnd_q, opnd_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, out_carry_q, out_carry_d, ovf_q, ovf_d;
  logic [NIBBLE_W-1:0] sum;
  logic co, last;
  assign last = idx_q == IW'(N - 1);
  ripple_carry_adder u_slice (
    .a (acc_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .b (opnd_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .ci(carry_q),
    .s (sum),
    .co(co)
  );
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    out_carry_d = out_carry_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.acc_clr) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        if (bus.in_valid) begin
          opnd_d  = bus.in_sub ? ~bus.in_data : bus.in_data;
          carry_d = bus.in_sub;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        acc_d[idx_q*NIBBLE_W +: NIBBLE_W] = sum;
        carry_d = co;
        idx_d   = idx_q + 1'b1;
        if (last) begin
          state_d     = RESP;
          out_carry_d = co;
          // acc_q MSB is still the pre-operation sign while the top nibble is computed
          ovf_d = ovf_q | ((acc_q[W-1] == opnd_q[W-1]) && (sum[NIBBLE_W-1] != acc_q[W-1]));
        end
      end
      RESP: state_d = bus.out_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      opnd_q      <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      out_carry_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      out_carry_q <= out_carry_d;
      ovf_q       <= ovf_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == RESP;
  assign bus.busy      = state_q != IDLE;
  assign bus.out_data  = acc_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_nibble_serial_accumulator.sv
// tb_nibble_serial_accumulator: directed self-checking bench for the nibble-serial accumulator
module tb_nibble_serial_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  nibble_serial_accumulator_if #(.W(16)) bus();
  nibble_serial_accumulator #(.W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
  endtask

  task automatic op(input logic [15:0] d, input logic s, output logic [15:0] r,
                    output logic c, output logic o, output int lat);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sub   = s;
    tick();
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    r = bus.out_data;
    c = bus.out_carry;
    o = bus.out_ovf;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.out_data !== 16'h0000) $display("FAIL reset_out_data got %h want 0000", bus.out_data); else passed++;
    total++; if ({bus.out_carry, bus.out_ovf} !== 2'b00) $display("FAIL reset_flags got %b want 00", {bus.out_carry, bus.out_ovf}); else passed++;
  endtask

  task automatic test_basic_add();
    logic [15:0] r; logic c, o; int lat;
    op(16'h1234, 1'b0, r, c, o, lat);
    total++; if (lat !== 4) $display("FAIL add1_latency got %0d want 4", lat); else passed++;
    total++; if (r !== 16'h1234) $display("FAIL add1_data got %h want 1234", r); else passed++;
    total++; if (c !== 1'b0) $display("FAIL add1_carry got %b want 0", c); else passed++;
    op(16'h0FFF, 1'b0, r, c, o, lat);
    total++; if (r !== 16'h2233) $display("FAIL add2_data got %h want 2233", r); else passed++;
    total++; if (c !== 1'b0) $display("FAIL add2_carry got %b want 0", c); else passed++;
  endtask

  task automatic test_carry_ripple();
    logic [15:0] r; logic c, o; int lat;
    clear();
    op(16'hFFFF, 1'b0, r, c, o, lat);
    total++; if (r !== 16'hFFFF) $display("FAIL ripple_setup got %h want ffff", r); else passed++;
    op(16'h0001, 1'b0, r, c, o, lat);
    total++; if (r !== 16'h0000) $display("FAIL ripple_data got %h want 0000", r); else passed++;
    total++; if (c !== 1'b1) $display("FAIL ripple_carry got %b want 1", c); else passed++;
    total++; if (o !== 1'b0) $display("FAIL ripple_ovf got %b want 0", o); else passed++;
  endtask

  task automatic test_sub();
    logic [15:0] r; logic c, o; int lat;
    clear();
    op(16'h0005, 1'b0, r, c, o, lat);
    op(16'h0007, 1'b1, r, c, o, lat);
    total++; if (r !== 16'hFFFE) $display("FAIL sub_data got %h want fffe", r); else passed++;
    total++; if (c !== 1'b0) $display("FAIL sub_borrow got %b want 0", c); else passed++;
    total++; if (o !== 1'b0) $display("FAIL sub_ovf got %b want 0", o); else passed++;
    op(16'h0002, 1'b1, r, c, o, lat);
    total++; if ({c, r} !== 17'h1FFFC) $display("FAIL sub_noborrow got %h want 1fffc", {c, r}); else passed++;
  endtask

  task automatic test_overflow();
    logic [15:0] r; logic c, o; int lat;
    clear();
    op(16'h7FFF, 1'b0, r, c, o, lat);
    total++; if (o !== 1'b0) $display("FAIL ovf_setup got %b want 0", o); else passed++;
    op(16'h0001, 1'b0, r, c, o, lat);
    total++; if (r !== 16'h8000) $display("FAIL ovf_data got %h want 8000", r); else passed++;
    total++; if (o !== 1'b1) $display("FAIL ovf_set got %b want 1", o); else passed++;
    op(16'h0001, 1'b0, r, c, o, lat);
    total++; if (r !== 16'h8001) $display("FAIL ovf_next_data got %h want 8001", r); else passed++;
    total++; if (o !== 1'b1) $display("FAIL ovf_sticky got %b want 1", o); else passed++;
    clear();
    total++; if (bus.out_data !== 16'h0000) $display("FAIL clr_acc got %h want 0000", bus.out_data); else passed++;
    total++; if (bus.out_ovf !== 1'b0) $display("FAIL clr_ovf got %b want 0", bus.out_ovf); else passed++;
  endtask

  task automatic test_clr_with_accept();
    logic [15:0] r; logic c, o; int lat;
    op(16'h1111, 1'b0, r, c, o, lat);
    bus.acc_clr = 1'b1;
    op(16'h0022, 1'b0, r, c, o, lat);
    total++; if (r !== 16'h0022) $display("FAIL clr_accept_data got %h want 0022", r); else passed++;
  endtask

  task automatic test_backpressure();
    logic [15:0] r; logic c, o; int lat;
    clear();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0100;
    bus.in_sub   = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    total++; if (lat !== 4) $display("FAIL bp_latency got %0d want 4", lat); else passed++;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = i[0] ? 1'b0 : 1'b1;
      bus.in_data  = 16'hA5A5 ^ 16'(i);
      bus.acc_clr  = 1'b1;
      tick();
      total++; if (bus.out_data !== 16'h0100) $display("FAIL bp_hold_data got %h want 0100", bus.out_data); else passed++;
      total++; if ({bus.out_valid, bus.in_ready} !== 2'b10) $display("FAIL bp_hold_hs got %b want 10", {bus.out_valid, bus.in_ready}); else passed++;
    end
    bus.in_valid  = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++; if ({bus.in_ready, bus.out_valid} !== 2'b10) $display("FAIL bp_release got %b want 10", {bus.in_ready, bus.out_valid}); else passed++;
    total++; if (bus.out_data !== 16'h0100) $display("FAIL bp_no_accept got %h want 0100", bus.out_data); else passed++;
    op(16'h0001, 1'b0, r, c, o, lat);
    total++; if (r !== 16'h0101) $display("FAIL bp_follow got %h want 0101", r); else passed++;
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] r; logic c, o; int lat;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h00FF;
    bus.in_sub   = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (bus.out_data !== 16'h0000) $display("FAIL midrst_acc got %h want 0000", bus.out_data); else passed++;
    total++; if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) $display("FAIL midrst_state got %b want 010", {bus.out_valid, bus.in_ready, bus.busy}); else passed++;
    op(16'h0001, 1'b0, r, c, o, lat);
    total++; if (r !== 16'h0001) $display("FAIL midrst_follow got %h want 0001", r); else passed++;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sub    = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_sub();
    test_overflow();
    test_clr_with_accept();
    test_backpressure();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end
endmodule
